data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory port: word-organised SRAM with byte-lane writes and a programmable wait-state count.
- Drives `ready_o`, which the CPU uses to stall its whole pipeline, and returns read data.
- Sits between the CPU data port and the SoC bus/top; `byte_select_i` and `data_i` arrive lane-aligned from the CPU byte-operation unit.

Parameters:
- ADDR_WIDTH, 10, word-address bits; DEPTH = 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- WAIT_STATES, 1, extra cycles before completion (0..255).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- addr_i  in  32  byte address, held stable by initiator until ready_o=1.
- data_i  in  32  write data, lane-aligned.
- rd_i  in  1  read request.
- wr_i  in  1  write request.
- byte_select_i  in  4  write lane enables, bit k = data_i[8k+7:8k].
- data_o  out  32  read data, full word; valid when ready_o=1 after a read.
- ready_o  out  1  transaction complete / responder idle.

Behaviour:
- Reset (async, rst_i=0): state=IDLE, wait counter=0, data_o=0. ready_o=1 whenever no request is present. Memory contents are not reset.
- Request: req = rd_i | wr_i. If rd_i and wr_i are both high, the access is a write and data_o returns the pre-write word.
- Address decode:
  - off = addr_i - BASE_ADDR; in_range = off < 4*DEPTH; index = off[ADDR_WIDTH+1:2].
  - off[1:0] is ignored for indexing.
- FSM states IDLE, WAIT, DONE:
  - IDLE: ready_o = ~req (combinational). On req, load counter with WAIT_STATES; next state is WAIT if WAIT_STATES>0, else DONE.
  - WAIT: ready_o=0. Counter decrements each cycle; when counter==1, next state is DONE.
  - DONE: ready_o=1. data_o was registered on the edge entering DONE (word at index; 0 if !in_range). The write is committed on the edge leaving DONE: lanes with byte_select_i[k]=1, only if in_range. Next state is always IDLE.
- Latency: request first seen in cycle 0 → ready_o=1 in cycle 1+WAIT_STATES. Throughput is one access per 2+WAIT_STATES cycles.
- Consecutive requests: the request present in the IDLE cycle after DONE starts a new access; ready_o drops combinationally in that cycle.
- Stall from the other port: if the CPU does not advance (instruction port not ready), the same request is re-executed. Reads and writes are idempotent, so this is permitted.
- Initiator changes addr/rd/wr while ready_o=0: undefined; a bench assertion flags it.
- Out-of-range: read returns 0 and the write is dropped; the handshake completes normally.
- byte_select_i=4'b0000 on a write: no memory change, handshake completes.
- Reset mid-operation (WAIT or DONE): access is abandoned, no write committed, return to IDLE.
- Counter is 8 bits wide and never wraps: the decrement is gated to WAIT.

Optional Feature:
- Macro: DATA_MEM_RESP_ERR_EN.
- Defined: adds output `err_o` (1 bit, reset 0). It is set in DONE when !in_range or the access is misaligned, and cleared on the next DONE without error.
  - Misaligned means a write whose byte_select_i is not in {0001,0010,0100,1000,0011,1100,1111}, or a byte_select_i lane below off[1:0].
  - Data behaviour is otherwise unchanged.
- Undefined: no err_o port and no error logic.

Decomposition:
- Shared package `data_mem_pkg`:
  - state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - WAIT_CNT_W=8;
  - legal byte_select patterns constant.
- Natural sub-module `byte_en_ram`: DEPTH×32 single-port array with per-byte write enables and registered read. The FSM, decode and counter stay in data_mem_responder.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with rd_i=1 → ready_o=1 after release only once idle, data_o=0, no access while in reset.
- Write then read, WAIT_STATES=2:
  - write 32'hDEADBEEF to BASE+0x10 with bs=1111 → ready_o low 3 cycles, high in cycle 3;
  - read BASE+0x10 → data_o=32'hDEADBEEF with ready_o=1 in cycle 3.
- Byte lanes: preload 0x10 with 32'h11223344; write data_i=32'hAA000000 with bs=1000 → read returns 32'hAA223344.
- Zero wait states (WAIT_STATES=0): back-to-back reads at 0x0 and 0x4 → each completes with ready_o=1 in cycle 1 and alternates low/high. Also check `ready_o` stays high with no request.
- Out-of-range: read BASE+4*DEPTH → data_o=0, ready_o completes. Write there → no array entry changes. With DATA_MEM_RESP_ERR_EN, err_o=1.
- Reset mid-WAIT: write 32'h12345678 with WAIT_STATES=4, assert rst_i=0 in cycle 2 → returns to IDLE, subsequent read of that address shows the old value.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the CPU data-memory responder.
// Contents: FSM state encoding, wait-counter width, the legal write
// byte-select patterns and helpers used by the optional error checker.
package data_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned WAIT_CNT_W = 8;

  // Byte, aligned half-word and full-word lane patterns a CPU store may use.
  localparam int unsigned N_LEGAL_BS = 7;
  localparam logic [N_LEGAL_BS*4-1:0] LEGAL_BS = {
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  // True when bs matches one of the legal store patterns.
  function automatic logic bs_legal(input logic [3:0] bs);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LEGAL_BS; i++) begin
      if (LEGAL_BS[i*4 +: 4] == bs) hit = 1'b1;
    end
    return hit;
  endfunction

  // True when an enabled lane sits below the byte offset of the address.
  function automatic logic bs_below_offset(input logic [3:0] bs, input logic [1:0] off);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bs[k] && (2'(k) < off)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_en_ram.sv
// byte_en_ram: DEPTH x 32 single-port array, per-byte write enables,
// registered read port.
// Ports:
//   clk, rst_n       clock / async active-low reset (read register only)
//   addr             word index
//   rd_en            load the read register this edge
//   rd_zero          with rd_en, load zero instead of the array word
//   wr_be, wr_data   byte-lane write enables and lane-aligned data
//   rd_data          registered read word
// The array itself is never reset.
module byte_en_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_be[k]) mem[addr][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  // Registered read; out-of-range accesses return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? 32'h0 : mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the CPU data-memory port.
// Word SRAM with byte-lane writes and WAIT_STATES extra cycles per access.
// Ports:
//   clk_i, rst_i     clock / async active-low reset
//   addr_i           byte address, held until ready_o
//   data_i           lane-aligned write data
//   rd_i, wr_i       request strobes (both high = write)
//   byte_select_i    write lane enables
//   data_o           read word, valid with ready_o after an access
//   ready_o          access complete / responder idle (combinational)
//   err_o            only with DATA_MEM_RESP_ERR_EN: out-of-range or
//                    misaligned access flag, updated on entry to DONE
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [3:0]  byte_select_i,
  output logic [31:0] data_o,
  output logic        ready_o
`ifdef DATA_MEM_RESP_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam logic [32:0]           SPAN      = 33'(1) << (ADDR_WIDTH + 2);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  logic [1:0]            state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  rd_fire;
  logic                  req;
  logic [31:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] index;
  logic [3:0]            wr_be;

  // Address decode relative to the window base.
  assign req      = rd_i | wr_i;
  assign off      = addr_i - BASE_ADDR;
  assign in_range = 33'(off) < SPAN;
  assign index    = off[ADDR_WIDTH+1:2];

  // State and wait-counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; rd_fire marks the edge that enters DONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          cnt_nxt = WAIT_LOAD;
          if (WAIT_STATES == 0) begin
            state_nxt = ST_DONE;
            rd_fire   = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = ST_DONE;
          rd_fire   = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Idle reports ready only with no request pending, so a new request stalls at once.
  assign ready_o = (state == ST_IDLE) ? ~req : (state == ST_DONE);

  // Write commits on the edge leaving DONE, so data_o carries the pre-write word.
  assign wr_be = (state == ST_DONE && wr_i && in_range) ? byte_select_i : 4'b0000;

  byte_en_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .addr    (index),
    .rd_en   (rd_fire),
    .rd_zero (~in_range),
    .wr_be   (wr_be),
    .wr_data (data_i),
    .rd_data (data_o)
  );

`ifdef DATA_MEM_RESP_ERR_EN
  logic misaligned;

  // Only stores can be misaligned; loads always return the full word.
  assign misaligned = wr_i &&
                      (!bs_legal(byte_select_i) || bs_below_offset(byte_select_i, off[1:0]));

  // Error flag sampled with the read data on entry to DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if (rd_fire) begin
      err_o <= ~in_range | misaligned;
    end
  end
`else
  logic unused_byte_off;
  assign unused_byte_off = ^off[1:0];
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Three instances:
//   dut 0: WAIT_STATES=2, BASE 0x0000
//   dut 1: WAIT_STATES=0, BASE 0x1000
//   dut 2: WAIT_STATES=4, BASE 0x0000
// A driver pushes expected responses into a scoreboard queue; a monitor
// pops and compares whenever a DUT completes (request present, ready high).
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rd    [3];
  logic        wr    [3];
  logic        rdy   [3];
  logic [3:0]  bs    [3];
`ifdef DATA_MEM_RESP_ERR_EN
  logic        err   [3];
`endif

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)) u_dut0 (
    .clk_i(clk), .rst_i(rstn[0]), .addr_i(addr[0]), .data_i(wdata[0]), .rd_i(rd[0]),
    .wr_i(wr[0]), .byte_select_i(bs[0]), .data_o(rdata[0]), .ready_o(rdy[0])
`ifdef DATA_MEM_RESP_ERR_EN
    , .err_o(err[0])
`endif
  );

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_dut1 (
    .clk_i(clk), .rst_i(rstn[1]), .addr_i(addr[1]), .data_i(wdata[1]), .rd_i(rd[1]),
    .wr_i(wr[1]), .byte_select_i(bs[1]), .data_o(rdata[1]), .ready_o(rdy[1])
`ifdef DATA_MEM_RESP_ERR_EN
    , .err_o(err[1])
`endif
  );

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(4)) u_dut2 (
    .clk_i(clk), .rst_i(rstn[2]), .addr_i(addr[2]), .data_i(wdata[2]), .rd_i(rd[2]),
    .wr_i(wr[2]), .byte_select_i(bs[2]), .data_o(rdata[2]), .ready_o(rdy[2])
`ifdef DATA_MEM_RESP_ERR_EN
    , .err_o(err[2])
`endif
  );

  typedef struct {
    int          k;
    logic        chk;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic int ws_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 4;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  // Expected error flag: out of window, or a store with an illegal/low lane pattern.
  function automatic logic exp_err(input int k, input logic w, input logic [31:0] a,
                                   input logic [3:0] b);
    logic [31:0] o;
    logic        legal;
    logic        low;
    o = a - base_of(k);
    case (b)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    low = 1'b0;
    for (int i = 0; i < 4; i++) if (b[i] && (i < int'(o[1:0]))) low = 1'b1;
    return (o >= 32'h0000_1000) || (w && (!legal || low));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one access and wait (bounded) for its completion.
  task automatic access(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input logic chk,
                        input logic [31:0] exp_d);
    exp_t e;
    int   t;
    @(posedge clk); #1;
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; bs[k] = b;
    e.k = k; e.chk = chk; e.data = exp_d; e.lat = 1 + ws_of(k); e.err = exp_err(k, w, a, b);
    sb_q.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy[k] && t < 200);
    if (!rdy[k]) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout dut%0d addr %h: ready never rose", k, a);
    end
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  // Monitor: completion comparisons, latency, and initiator-stability assertion.
  int          lat       [3] = '{0, 0, 0};
  logic        prev_hold [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] prev_addr [3];
  logic        prev_rd   [3];
  logic        prev_wr   [3];
  exp_t        mon_e;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn[k]) begin
        lat[k]       = 0;
        prev_hold[k] = 1'b0;
      end else begin
        if (prev_hold[k] && (addr[k] !== prev_addr[k] || rd[k] !== prev_rd[k] ||
                             wr[k] !== prev_wr[k])) begin
          n_errors++;
          $display("FAIL stability dut%0d: request changed while stalled", k);
        end
        if ((rd[k] | wr[k]) && !rdy[k]) begin
          lat[k]++;
        end else if ((rd[k] | wr[k]) && rdy[k]) begin
          if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected completion dut%0d addr %h", k, addr[k]);
          end else begin
            mon_e = sb_q.pop_front();
            check($sformatf("dut id"), 32'(k), 32'(mon_e.k));
            check($sformatf("latency dut%0d addr %h", k, addr[k]), 32'(lat[k]), 32'(mon_e.lat));
            if (mon_e.chk) check($sformatf("data dut%0d addr %h", k, addr[k]), rdata[k], mon_e.data);
`ifdef DATA_MEM_RESP_ERR_EN
            check($sformatf("err dut%0d addr %h", k, addr[k]), 32'(err[k]), 32'(mon_e.err));
`endif
          end
          lat[k] = 0;
        end
        prev_hold[k] = (rd[k] | wr[k]) & ~rdy[k];
        prev_addr[k] = addr[k];
        prev_rd[k]   = rd[k];
        prev_wr[k]   = wr[k];
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; rd[k] = 1'b1; wr[k] = 1'b0;
      addr[k] = base_of(k); wdata[k] = '0; bs[k] = '0;
    end

    // Reset held 3 cycles with a read pending: nothing executes.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset data_o dut0", rdata[0], 32'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rd[k] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post-reset ready dut%0d", k), 32'(rdy[k]), 32'h1);
      check($sformatf("post-reset data dut%0d", k), rdata[k], 32'h0);
    end

    // dut0: write/read, byte lanes, rd+wr, zero lanes, out of range.
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'h0);
    access(0, 1, 0, 32'h10, 32'h0,        4'b0000, 1, 32'hDEADBEEF);
    access(0, 0, 1, 32'h10, 32'h11223344, 4'b1111, 1, 32'hDEADBEEF);
    access(0, 0, 1, 32'h10, 32'hAA000000, 4'b1000, 1, 32'h11223344);
    access(0, 1, 0, 32'h10, 32'h0,        4'b0000, 1, 32'hAA223344);
    access(0, 0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1, 32'hAA223344);
    access(0, 1, 0, 32'h10, 32'h0,        4'b0000, 1, 32'hAA223344);
    access(0, 0, 1, 32'h14, 32'h01020304, 4'b1111, 0, 32'h0);
    access(0, 1, 1, 32'h14, 32'h55667788, 4'b0011, 1, 32'h01020304);
    access(0, 1, 0, 32'h14, 32'h0,        4'b0000, 1, 32'h01027788);
    access(0, 0, 1, 32'h00, 32'h0BADF00D, 4'b1111, 0, 32'h0);
    access(0, 1, 0, 32'h1000, 32'h0,      4'b0000, 1, 32'h0);
    access(0, 0, 1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 1, 32'h0);
    access(0, 1, 0, 32'h00, 32'h0,        4'b0000, 1, 32'h0BADF00D);
    access(0, 1, 0, 32'h12, 32'h0,        4'b0000, 1, 32'hAA223344);
    access(0, 0, 1, 32'hFFC, 32'h76543210, 4'b1111, 0, 32'h0);
    access(0, 1, 0, 32'hFFC, 32'h0,       4'b0000, 1, 32'h76543210);
    idle(0);

    // dut1: zero wait states, idle ready, back-to-back reads, window edges.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle ready dut1", 32'(rdy[1]), 32'h1);
    end
    access(1, 0, 1, 32'h1000, 32'hA5A5A5A5, 4'b1111, 0, 32'h0);
    access(1, 0, 1, 32'h1004, 32'h5A5A5A5A, 4'b1111, 0, 32'h0);
    access(1, 1, 0, 32'h1000, 32'h0, 4'b0000, 1, 32'hA5A5A5A5);
    access(1, 1, 0, 32'h1004, 32'h0, 4'b0000, 1, 32'h5A5A5A5A);
    access(1, 1, 0, 32'h1000, 32'h0, 4'b0000, 1, 32'hA5A5A5A5);
    access(1, 1, 0, 32'h0000, 32'h0, 4'b0000, 1, 32'h0);
    access(1, 1, 0, 32'h2000, 32'h0, 4'b0000, 1, 32'h0);
    idle(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle ready after burst dut1", 32'(rdy[1]), 32'h1);
    end

    // dut2: reset in the middle of WAIT abandons the write.
    access(2, 0, 1, 32'h20, 32'hCAFEF00D, 4'b1111, 0, 32'h0);
    access(2, 1, 0, 32'h20, 32'h0, 4'b0000, 1, 32'hCAFEF00D);
    idle(2);
    @(posedge clk); #1;
    wr[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h12345678; bs[2] = 4'b1111;
    @(negedge clk);
    check("stall ready cycle0 dut2", 32'(rdy[2]), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall ready cycle1 dut2", 32'(rdy[2]), 32'h0);
    @(posedge clk); #1;
    rstn[2] = 1'b0;
    wr[2]   = 1'b0;
    @(negedge clk);
    check("mid-reset ready dut2", 32'(rdy[2]), 32'h1);
    check("mid-reset data dut2", rdata[2], 32'h0);
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    access(2, 1, 0, 32'h20, 32'h0, 4'b0000, 1, 32'hCAFEF00D);
    idle(2);

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
